// File: rtl/inst_sram_axi_bridge_pkg.sv
// Shared types and AXI constants for the instruction SRAM-to-AXI read bridge.
package inst_sram_axi_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [2:0] ARSIZE_WORD   = 3'b010;
  localparam logic [1:0] ARBURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [7:0] ARLEN_SINGLE  = 8'h00;

endpackage

// File: rtl/inst_sram_axi_bridge_if.sv
// Fetch-side SRAM port, pipeline control and AXI read channels of the bridge.
// slave: the bridge's view; master: the surrounding fetch stage / AXI slave.
interface inst_sram_axi_bridge_if;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_we;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic        flush;
  logic        ibuf_inv;
  logic [31:0] inst_sram_rdata;
  logic        inst_rdata_ok;
  logic        fetch_stall;
  logic        bus_err;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport slave (
    input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata, flush, ibuf_inv,
    input  arready, rid, rdata, rresp, rlast, rvalid,
    output inst_sram_rdata, inst_rdata_ok, fetch_stall, bus_err,
    output arid, araddr, arlen, arsize, arburst, arvalid, rready
  );

  modport master (
    output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata, flush, ibuf_inv,
    output arready, rid, rdata, rresp, rlast, rvalid,
    input  inst_sram_rdata, inst_rdata_ok, fetch_stall, bus_err,
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready
  );
endinterface

// File: rtl/inst_sram_axi_bridge_hit_buf.sv
// One-entry fetch hit buffer (valid/tag/data); only built with INST_BRIDGE_HIT_BUF_EN.
module inst_hit_buf (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inv_i,
  input  logic        wr_en_i,
  input  logic        wr_ok_i,
  input  logic [31:0] wr_tag_i,
  input  logic [31:0] wr_data_i,
  input  logic [31:0] lookup_i,
  output logic        hit_o,
  output logic [31:0] hit_data_o
);

  logic        valid_q, valid_d;
  logic [31:0] tag_q, tag_d;
  logic [31:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr_en_i) begin
      tag_d   = wr_tag_i;
      data_d  = wr_data_i;
      valid_d = wr_ok_i;
    end
    // An invalidate beats a same-cycle fill.
    if (inv_i) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign hit_o      = valid_q && (tag_q == lookup_i);
  assign hit_data_o = data_q;

endmodule

// File: rtl/inst_sram_axi_bridge.sv
// Fetch-port responder issuing single-beat AXI reads; one read outstanding at most.
// Optional one-entry hit buffer enabled by defining INST_BRIDGE_HIT_BUF_EN.
module inst_sram_axi_bridge
  import inst_sram_axi_bridge_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'h0
) (
  input  logic                  clk,
  input  logic                  resetn,
  inst_sram_axi_bridge_if.slave bus
);

  state_e      state_q, state_d;
  logic [31:0] araddr_q, araddr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        discard_q, discard_d;
  logic        bus_err_q, bus_err_d;
  logic        fetch_stall_c, arvalid_c, rready_c, rdata_ok_c;
  logic        buf_wr;
  logic        hit;
  logic [31:0] hit_data;

  always_comb begin
    state_d       = state_q;
    araddr_d      = araddr_q;
    rdata_d       = rdata_q;
    discard_d     = discard_q;
    bus_err_d     = bus_err_q;
    buf_wr        = 1'b0;
    fetch_stall_c = 1'b0;
    arvalid_c     = 1'b0;
    rready_c      = 1'b0;
    rdata_ok_c    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.inst_sram_en && !bus.flush) begin
          fetch_stall_c = 1'b1;
          if (bus.inst_sram_we != 4'h0) bus_err_d = 1'b1;
          if (hit) begin
            rdata_d = hit_data;
            state_d = ST_DONE;
          end else begin
            araddr_d = bus.inst_sram_addr;
            state_d  = ST_AR;
          end
        end
      end
      ST_AR: begin
        arvalid_c     = 1'b1;
        fetch_stall_c = 1'b1;
        if (bus.flush) discard_d = 1'b1;
        if (bus.arready) state_d = ST_R;
      end
      ST_R: begin
        rready_c      = 1'b1;
        fetch_stall_c = 1'b1;
        if (bus.flush) discard_d = 1'b1;
        if (bus.rvalid) begin
          if (bus.rresp != AXI_RESP_OKAY) bus_err_d = 1'b1;
          // A flush arriving with the data kills it just like an earlier one.
          if (discard_q || bus.flush) begin
            state_d = ST_IDLE;
          end else begin
            rdata_d = bus.rdata;
            buf_wr  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        rdata_ok_c = !bus.flush;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_IDLE) discard_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      araddr_q  <= '0;
      rdata_q   <= '0;
      discard_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      araddr_q  <= araddr_d;
      rdata_q   <= rdata_d;
      discard_q <= discard_d;
      bus_err_q <= bus_err_d;
    end
  end

  logic unused_ok;
`ifdef INST_BRIDGE_HIT_BUF_EN
  inst_hit_buf u_hit_buf (
    .clk        (clk),
    .resetn     (resetn),
    .inv_i      (bus.ibuf_inv),
    .wr_en_i    (buf_wr),
    .wr_ok_i    (bus.rresp == AXI_RESP_OKAY),
    .wr_tag_i   (araddr_q),
    .wr_data_i  (bus.rdata),
    .lookup_i   (bus.inst_sram_addr),
    .hit_o      (hit),
    .hit_data_o (hit_data)
  );
  assign unused_ok = ^{bus.inst_sram_wdata, bus.rid, bus.rlast};
`else
  assign hit       = 1'b0;
  assign hit_data  = '0;
  assign unused_ok = ^{bus.inst_sram_wdata, bus.rid, bus.rlast, bus.ibuf_inv, buf_wr};
`endif

  assign bus.inst_sram_rdata = rdata_q;
  assign bus.inst_rdata_ok   = rdata_ok_c;
  assign bus.fetch_stall     = fetch_stall_c;
  assign bus.bus_err         = bus_err_q;
  assign bus.arid            = AXI_ID;
  assign bus.araddr          = araddr_q;
  assign bus.arlen           = ARLEN_SINGLE;
  assign bus.arsize          = ARSIZE_WORD;
  assign bus.arburst         = ARBURST_INCR;
  assign bus.arvalid         = arvalid_c;
  assign bus.rready          = rready_c;

endmodule
